// File: rtl/roi_resize_pkg.sv
// roi_resize_pkg: shared widths and state encoding for the ROI nearest-neighbour resizer
package roi_resize_pkg;
  localparam int HOR_W = 11;
  localparam int VER_W = 9;
  localparam int PIX_W = 24;
  localparam int ACCX_W = 12;
  localparam int ACCY_W = 10;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
endpackage

// File: rtl/roi_nn_resize_dda_step.sv
// dda_step: one integer DDA step, selects when the accumulated step reaches the modulus
module dda_step
  import roi_resize_pkg::*;
#(
  parameter int W = ACCX_W
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] step,
  input  logic [W-1:0] modulus,
  output logic         sel,
  output logic [W-1:0] acc_next
);
  logic [W-1:0] sum;
  assign sum = acc + step;
  assign sel = sum >= modulus;
  assign acc_next = sel ? sum - modulus : sum;
endmodule

// File: rtl/roi_nn_resize.sv
// roi_nn_resize: streams a cropped ROI and keeps a DST_W x DST_H nearest-neighbour subset
module roi_nn_resize
  import roi_resize_pkg::*;
#(
  parameter int DST_W = 64,
  parameter int DST_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HOR_W-1:0] InWidth,
  input  logic [VER_W-1:0] InHeight,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             de_in,
  input  logic             valid_in,
  input  logic             vsync_in,
  output logic             ready_out,
  output logic [PIX_W-1:0] pixel_out,
  output logic             valid_out,
  output logic             sof_out,
  output logic             eol_out,
  output logic             eof_out,
  output logic             size_err,
  output logic             frame_abort
);
  state_t state;
  logic de_q, vs_q, err_q, line_sel;
  logic [HOR_W-1:0] in_w, x_cnt, out_x, w, x_b, ox_b;
  logic [VER_W-1:0] in_h, lines, out_y, h, oy_b;
  logic [VER_W:0] lines_inc;
  logic [ACCX_W-1:0] acc_x, accx_b, accx_next;
  logic [ACCY_W-1:0] acc_y, accy_b, accy_next;
  logic idle, active, live, take, start, x_start, line_end, abort, bad, err;
  logic hsel, vsel, in_range, cur_sel, emit, eol, last_line;

  assign idle = state == IDLE;
  assign active = state == ACTIVE;
  assign live = idle | active;
  assign ready_out = idle;
  assign take = de_in & valid_in;
  assign start = idle & take;
  // the frame-opening pixel is also the first line start, even if de rose earlier while idle
  assign x_start = start | (active & de_in & ~de_q);
  assign line_end = active & ~de_in & de_q;
  assign abort = active & vsync_in & ~vs_q;
  // during the latch cycle the live inputs stand in for the not-yet-latched registers
  assign w = idle ? InWidth : in_w;
  assign h = idle ? InHeight : in_h;
  assign bad = InWidth < HOR_W'(DST_W) || InHeight < VER_W'(DST_H) || InWidth == '0 || InHeight == '0;
  assign err = idle ? bad : err_q;
  assign x_b = x_start ? '0 : x_cnt;
  assign accx_b = x_start ? '0 : acc_x;
  assign accy_b = idle ? '0 : acc_y;
  assign ox_b = idle ? '0 : out_x;
  assign oy_b = idle ? '0 : out_y;
  assign in_range = x_b < w;
  assign cur_sel = x_start ? vsel : line_sel;
  assign emit = take & live & ~abort & ~err & in_range & hsel & cur_sel;
  assign eol = ox_b == HOR_W'(DST_W - 1);
  assign lines_inc = {1'b0, lines} + (VER_W + 1)'(1);
  assign last_line = lines_inc >= {1'b0, in_h};

  dda_step #(.W(ACCX_W)) u_dda_x (
    .acc(accx_b),
    .step(ACCX_W'(DST_W)),
    .modulus(ACCX_W'(w)),
    .sel(hsel),
    .acc_next(accx_next)
  );

  dda_step #(.W(ACCY_W)) u_dda_y (
    .acc(accy_b),
    .step(ACCY_W'(DST_H)),
    .modulus(ACCY_W'(h)),
    .sel(vsel),
    .acc_next(accy_next)
  );

  // frame control: state, edge history, latched ROI size and both DDA accumulators
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      de_q <= 1'b0;
      vs_q <= 1'b0;
      err_q <= 1'b0;
      line_sel <= 1'b0;
      in_w <= '0;
      in_h <= '0;
      x_cnt <= '0;
      lines <= '0;
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      de_q <= de_in;
      vs_q <= vsync_in;
      state <= abort ? IDLE : start ? ACTIVE : (line_end & last_line) ? DONE : (state == DONE) ? IDLE : state;
      if (start) begin
        in_w <= InWidth;
        in_h <= InHeight;
        err_q <= bad;
        lines <= '0;
        acc_y <= '0;
      end
      if (x_start) line_sel <= vsel;
      if (take & live & in_range) begin
        x_cnt <= x_b + HOR_W'(1);
        acc_x <= accx_next;
      end
      if (line_end) begin
        lines <= lines_inc[VER_W-1:0];
        acc_y <= accy_next;
      end
    end

  // registered output stage, one cycle behind the consumed pixel
  always_ff @(posedge clk)
    if (rst) begin
      pixel_out <= '0;
      valid_out <= 1'b0;
      sof_out <= 1'b0;
      eol_out <= 1'b0;
      eof_out <= 1'b0;
      size_err <= 1'b0;
      frame_abort <= 1'b0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      valid_out <= emit;
      sof_out <= emit & (ox_b == '0) & (oy_b == '0);
      eol_out <= emit & eol;
      eof_out <= emit & eol & (oy_b == VER_W'(DST_H - 1));
      size_err <= start & bad;
      frame_abort <= abort;
      if (emit) pixel_out <= pixel_in;
      if (emit | start) begin
        out_x <= !emit ? ox_b : eol ? '0 : ox_b + HOR_W'(1);
        out_y <= !(emit & eol) ? oy_b : (oy_b == VER_W'(DST_H - 1)) ? '0 : oy_b + VER_W'(1);
      end
    end
endmodule

// File: tb/tb_roi_nn_resize.sv
// tb_roi_nn_resize: directed frames against a DDA position model of the resizer
module tb_roi_nn_resize;
  localparam int DW = 64;
  localparam int DH = 64;
  logic clk = 0, rst = 1;
  logic [10:0] in_width = '0;
  logic [8:0] in_height = '0;
  logic [23:0] pix = '0;
  logic de = 0, valid = 0, vsync = 0;
  logic ready_out, valid_out, sof_out, eol_out, eof_out, size_err, frame_abort;
  logic [23:0] pixel_out;
  int checks = 0, errors = 0;
  int n_valid = 0, n_eof = 0, n_sof = 0, n_eol = 0, n_serr = 0, n_abort = 0, pos_bad = 0;
  int mk = 0, mr = 0, seen_gen = 0;
  int m_w = 0, m_h = 0, m_gen = 0;
  int b_valid, b_eof, b_sof, b_eol, b_serr, b_abort, b_bad;

  roi_nn_resize #(.DST_W(DW), .DST_H(DH)) dut (
    .clk(clk), .rst(rst), .InWidth(in_width), .InHeight(in_height), .pixel_in(pix),
    .de_in(de), .valid_in(valid), .vsync_in(vsync), .ready_out(ready_out),
    .pixel_out(pixel_out), .valid_out(valid_out), .sof_out(sof_out), .eol_out(eol_out),
    .eof_out(eof_out), .size_err(size_err), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [23:0] exp_pix;
    if (m_gen != seen_gen) begin
      seen_gen = m_gen;
      mk = 0;
      mr = 0;
    end
    if (size_err) n_serr++;
    if (frame_abort) n_abort++;
    if (!valid_out && (sof_out || eol_out || eof_out)) pos_bad++;
    if (valid_out) begin
      n_valid++;
      if (eof_out) n_eof++;
      if (sof_out) n_sof++;
      if (eol_out) n_eol++;
      exp_pix = {12'(((mr + 1) * m_h + DH - 1) / DH - 1), 12'(((mk + 1) * m_w + DW - 1) / DW - 1)};
      if ({pixel_out, sof_out, eol_out, eof_out} !== {exp_pix, mk == 0 && mr == 0, mk == DW - 1, mk == DW - 1 && mr == DH - 1})
        pos_bad++;
      mk++;
      if (mk == DW) begin
        mk = 0;
        mr++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame(input int w, input int h, input int ab_line, input int rs_line, input bit bubble);
    b_valid = n_valid; b_eof = n_eof; b_sof = n_sof; b_eol = n_eol;
    b_serr = n_serr; b_abort = n_abort; b_bad = pos_bad;
    m_w = w; m_h = h; m_gen++;
    in_width = 11'(w);
    in_height = 9'(h);
    vsync = 1; step(); step();
    vsync = 0; step(); step();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (bubble && x % 7 == 3) begin
          de = 1; valid = 0; step();
        end
        de = 1; valid = 1; pix = {12'(y), 12'(x)};
        if (y == ab_line && x == w / 2) begin
          vsync = 1; step();
          check("abort_pulse", frame_abort, 1);
          check("abort_ready", ready_out, 1);
          de = 0; valid = 0; step();
          check("abort_single", frame_abort, 0);
          vsync = 0; step(); step();
          return;
        end
        if (y == rs_line && x == w / 2) begin
          rst = 1; de = 0; valid = 0; step();
          check("rst_outputs", {ready_out, valid_out, sof_out, eol_out, eof_out, size_err, frame_abort, pixel_out}, {1'b1, 30'b0});
          rst = 0; step();
          return;
        end
        step();
        if (x == 0 && y == 0) check("busy_after_first", ready_out, 0);
      end
      de = 0; valid = 0; step(); step();
    end
    repeat (3) step();
    check("idle_after_frame", ready_out, 1);
  endtask

  task automatic check_frame(input string tag, input int nv, input int rows, input int full);
    check({tag, "_valid"}, n_valid - b_valid, nv);
    check({tag, "_eol"}, n_eol - b_eol, rows);
    check({tag, "_sof"}, n_sof - b_sof, nv > 0 ? 1 : 0);
    check({tag, "_eof"}, n_eof - b_eof, full);
    check({tag, "_position"}, pos_bad - b_bad, 0);
  endtask

  initial begin
    repeat (3) step();
    check("reset_outputs", {ready_out, valid_out, sof_out, eol_out, eof_out, size_err, frame_abort, pixel_out}, {1'b1, 30'b0});
    rst = 0; step();
    drive_frame(64, 64, -1, -1, 0);
    check_frame("f64", 4096, 64, 1);
    drive_frame(128, 128, -1, -1, 0);
    check_frame("f128", 4096, 64, 1);
    drive_frame(100, 80, -1, -1, 1);
    check_frame("f100x80", 4096, 64, 1);
    drive_frame(32, 32, -1, -1, 0);
    check_frame("f32", 0, 0, 0);
    check("f32_size_err", n_serr - b_serr, 1);
    drive_frame(128, 128, 10, -1, 0);
    check_frame("fabort", 320, 5, 0);
    check("fabort_count", n_abort - b_abort, 1);
    drive_frame(64, 64, -1, -1, 0);
    check_frame("f_after_abort", 4096, 64, 1);
    check("no_err_good", n_serr - b_serr, 0);
    drive_frame(128, 128, -1, 5, 0);
    check_frame("frst", 160, 2, 0);
    drive_frame(64, 64, -1, -1, 0);
    check_frame("f_after_rst", 4096, 64, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
